fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Receiving end of the instruction-fetch interface, placed between the fetch stage and decode.
//   Captures each fetched {pc, insn} pair into a small FIFO and delivers it to decode over a
//   valid/ready handshake.
//   Drives the fetch stage's PC write-enable back, stalling fetch when the queue is full.
//   Flushes all queued wrong-path instructions when a jump/branch redirect is taken.
// PARAMETERS
//   ADDR_W   32            instruction address width (matches `instructionAddrPath)
//   INSN_W   32            instruction width (matches `instruction)
//   DEPTH    4             queue entries; power of two, >= 2
//   NOP      32'h00000013  value driven on out_insn when the queue is empty (addi x0,x0,0)
// PORTS
//   clk            in   1              single clock, rising edge
//   rst            in   1              reset, asynchronous, active-low
//   in_pc          in   ADDR_W         PC of the instruction currently presented by fetch
//   in_insn        in   INSN_W         instruction word at in_pc
//   in_valid       in   1              in_pc/in_insn are valid this cycle
//   if_wr_enable   out  1              PC write-enable to fetch; 1 = PC advances at next edge
//   flush          in   1              redirect taken this cycle (same as fetch jump_enable)
//   out_pc         out  ADDR_W         head entry PC
//   out_insn       out  INSN_W         head entry instruction
//   out_valid      out  1              head entry valid
//   out_ready      in   1              decode accepts head this cycle
//   occupancy      out  log2(DEPTH)+1  number of valid entries
// BEHAVIOUR
//   Storage and outputs
//   - Circular buffer: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
//   - Reset (rst=0, async): count=0, wr_ptr=0, rd_ptr=0. Entry contents are don't-care.
//   - Reset output values: out_valid=0, out_pc=0, out_insn=NOP, occupancy=0, if_wr_enable=1.
//   - All outputs are combinational from the registered state and inputs; there is no input->output bypass.
//   Handshake events
//   - push = in_valid & (count != DEPTH) & ~flush
//   - pop  = out_valid & out_ready & ~flush
//   - if_wr_enable = (count != DEPTH) | flush
//     - Fetch advances exactly when its current instruction is captured.
//     - It is also forced to 1 during flush so the PC loads the jump target.
//   - Latency: a pair pushed at edge N appears at the head after edge N if the queue was empty.
//     An empty queue therefore adds 1 cycle of latency.
//   - out_valid = (count != 0). When count == 0: out_pc = 0, out_insn = NOP.
//   Update at each clock edge
//   - push only: write entry[wr_ptr], wr_ptr++, count++.
//   - pop only: rd_ptr++, count--.
//   - push & pop together: write and read both occur and count is unchanged.
//     This is legal at any 0 < count < DEPTH.
//   - Full (count == DEPTH): push=0 and if_wr_enable=0. A pop in that cycle still occurs.
//     The freed slot reopens if_wr_enable in the next cycle; there is no same-cycle full bypass.
//   - flush: count=0 and rd_ptr=wr_ptr. Flush has priority over push and pop.
//     No entry is delivered in the flush cycle, and the in_* pair presented that cycle is dropped.
//   - in_valid=0: no push, and if_wr_enable still follows the rule above.
//   - Any value of out_ready while out_valid=0 is ignored.
//   - Reset asserted mid-operation discards all entries immediately (asynchronous).
//   - count never exceeds DEPTH or underflows below 0; an implementation that can is a bug (bench asserts it).
// TESTING
//   1. Reset, then present in_valid=1, pc 0x0,0x4,0x8 with out_ready=1.
//      -> out_valid rises 1 cycle after each push; out pc sequence is 0x0,0x4,0x8.
//   2. out_ready=0, push 4 pairs (pc 0x10..0x1C).
//      -> occupancy=4, if_wr_enable=0; the 5th pair is not captured and fetch holds.
//   3. From full, out_ready=1 for 1 cycle.
//      -> head 0x10 is popped; next cycle if_wr_enable=1 and occupancy=3.
//   4. Steady state with in_valid=1 and out_ready=1 and occupancy=2.
//      -> occupancy stays 2 every cycle; pc order is preserved across the pointer wrap.
//   5. Queue holds 3 entries, flush=1 with in_valid=1 and out_ready=1.
//      -> next cycle occupancy=0, out_valid=0, out_insn=NOP; the in_* pair is dropped; if_wr_enable=1.
//   6. Assert rst=0 asynchronously mid-stream with occupancy=3.
//      -> out_valid=0 and occupancy=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: captures {pc, insn} pairs from fetch,
// hands them to decode over valid/ready, stalls fetch when full, drops on redirect.
module fetch_queue #(
    parameter int                ADDR_W = 32,
    parameter int                INSN_W = 32,
    parameter int                DEPTH  = 4,
    parameter logic [INSN_W-1:0] NOP    = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [INSN_W-1:0]          in_insn,
    input  logic                       in_valid,
    output logic                       if_wr_enable,
    input  logic                       flush,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INSN_W-1:0]          out_insn,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INSN_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [ENT_W-1:0] head;

    assign full  = (count_q == FULL);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    assign push = in_valid & ~full & ~flush;
    assign pop  = ~empty & out_ready & ~flush;

    assign if_wr_enable = ~full | flush;
    assign out_valid    = ~empty;
    assign out_pc       = empty ? '0  : head[ENT_W-1:INSN_W];
    assign out_insn     = empty ? NOP : head[INSN_W-1:0];
    assign occupancy    = count_q;

    // Next-state: flush empties the queue and wins over push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_pc, in_insn};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset discards every entry immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scoreboard of captured pairs, checked at the head
// every cycle on the falling edge.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [31:0] in_pc;
    logic [31:0] in_insn;
    logic        in_valid;
    logic        if_wr_enable;
    logic        flush;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  occupancy;

    ent_t sb[$];
    int n_cmp;
    int n_err;
    logic [31:0] fpc;

    fetch_queue #(
        .ADDR_W(32),
        .INSN_W(32),
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_pc       (in_pc),
        .in_insn     (in_insn),
        .in_valid    (in_valid),
        .if_wr_enable(if_wr_enable),
        .flush       (flush),
        .out_pc      (out_pc),
        .out_insn    (out_insn),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .occupancy   (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk_insn(logic [31:0] pc);
        return (pc << 5) ^ 32'hA5C30033;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, then advance the model past posedge
    task automatic cycle();
        logic push;
        logic pop;
        int   sz;
        in_pc   = fpc;
        in_insn = mk_insn(fpc);
        @(negedge clk);
        sz = sb.size();
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("wr_enable", 64'(if_wr_enable), 64'((sz != DEPTH) || flush));
        chk("out_valid", 64'(out_valid), 64'(sz != 0));
        if (sz == 0) begin
            chk("empty_pc", 64'(out_pc), 64'h0);
            chk("empty_insn", 64'(out_insn), 64'(NOP));
        end else begin
            chk("head_pc", 64'(out_pc), 64'(sb[0].pc));
            chk("head_insn", 64'(out_insn), 64'(sb[0].insn));
        end
        push = in_valid && (sz != DEPTH) && !flush;
        pop  = (sz != 0) && out_ready && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                sb.push_back('{pc: fpc, insn: mk_insn(fpc)});
                fpc = fpc + 32'd4;
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        fpc       = 32'h0;
        in_pc     = 32'h0;
        in_insn   = mk_insn(32'h0);
        #2;
        chk("rst_occ", 64'(occupancy), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_pc", 64'(out_pc), 64'h0);
        chk("rst_insn", 64'(out_insn), 64'(NOP));
        chk("rst_wren", 64'(if_wr_enable), 64'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: three pushes with decode always ready, then drain
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t1_next_pc", 64'(fpc), 64'hC);

        // 2: fill with decode stalled; the fifth pair is held
        fpc       = 32'h10;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t2_occ", 64'(occupancy), 64'h4);
        chk("t2_wren", 64'(if_wr_enable), 64'h0);
        chk("t2_fpc_held", 64'(fpc), 64'h20);

        // 3: one pop from full; slot reopens the next cycle
        out_ready = 1'b1;
        chk("t3_head", 64'(out_pc), 64'h10);
        cycle();
        out_ready = 1'b0;
        chk("t3_occ", 64'(occupancy), 64'h3);
        chk("t3_wren", 64'(if_wr_enable), 64'h1);
        cycle();

        // 4: drain to 2, then steady state across pointer wrap
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() > 2; i++) cycle();
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("t4_occ", 64'(occupancy), 64'h2);
        end

        // 5: grow to 3 entries, then flush with a pair presented
        out_ready = 1'b0;
        for (int i = 0; i < 4 && sb.size() < 3; i++) cycle();
        chk("t5_pre_occ", 64'(occupancy), 64'h3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        fpc      = 32'h100;
        chk("t5_occ", 64'(occupancy), 64'h0);
        chk("t5_valid", 64'(out_valid), 64'h0);
        chk("t5_insn", 64'(out_insn), 64'(NOP));
        chk("t5_wren", 64'(if_wr_enable), 64'h1);
        cycle();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // 6: async reset mid-stream at occupancy 3
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4 && sb.size() < 3; i++) cycle();
        chk("t6_pre_occ", 64'(occupancy), 64'h3);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_occ", 64'(occupancy), 64'h0);
        chk("t6_valid", 64'(out_valid), 64'h0);
        chk("t6_insn", 64'(out_insn), 64'(NOP));
        sb.delete();
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
